// File: rtl/ntt_stage_sched.sv
`timescale 1ns/1ps
`ifndef Datawidth
`define Datawidth 16
`endif
// Purpose : in-place radix-2 forward NTT scheduler; holds N coefficients and issues butterflies stage by stage.
// Latency : a full transform takes LOGN*(N/2+PIPE_LAT) cycles after start; done pulses in the following cycle.
// Backpres: none; one pair per cycle is issued and each stage drains fully before the next stage reads.
// Ports   : start/done/busy control; load_* coefficient write; rd_addr/rd_data registered readback;
//           tw_addr/tw_data combinational twiddle ROM; bf_* butterfly issue and bf_valid/bf_*out results.
module ntt_stage_sched #(
    parameter int LOGN     = 4,
    parameter int PIPE_LAT = 6,
    parameter int W        = `Datawidth + 1
) (
    input  logic            clk,
    input  logic            rst_n,      // active-high synchronous reset
    input  logic            start,
    input  logic            load_we,
    input  logic [LOGN-1:0] load_addr,
    input  logic [W-1:0]    load_data,
    input  logic [LOGN-1:0] rd_addr,
    output logic [W-1:0]    rd_data,
    output logic [LOGN-1:0] tw_addr,
    input  logic [W-1:0]    tw_data,
    output logic            bf_en,
    output logic [W-1:0]    bf_x,
    output logic [W-1:0]    bf_y,
    output logic [W-1:0]    bf_w,
    input  logic            bf_valid,
    input  logic [W-1:0]    bf_xout,
    input  logic [W-1:0]    bf_yout,
    output logic            busy,
    output logic            done
);
    localparam int N  = 1 << LOGN;
    localparam int SW = $clog2(LOGN + 1);
    localparam int OW = $clog2(N + PIPE_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state;
    logic [SW-1:0]   stage;
    logic [LOGN-1:0] pair;
    logic [OW-1:0]   outstanding;
    logic [LOGN-1:0] sr_top [PIPE_LAT];
    logic [LOGN-1:0] sr_bot [PIPE_LAT];
    logic [W-1:0]    mem [N];

    logic [LOGN-1:0] len, grp, jdx, top, bot;
    logic            wb_en, last_pair, last_wb;

    // Pair index -> butterfly addresses. grp is the block within the stage,
    // jdx the offset inside the block; twiddles come from a bit-reversed table.
    always_comb begin
        len     = LOGN'(N / 2) >> stage;
        grp     = pair >> (LOGN - 1 - int'(stage));
        jdx     = pair & (len - 1'b1);
        top     = (grp << (LOGN - int'(stage))) | jdx;
        bot     = top + len;
        tw_addr = (LOGN'(1) << stage) + grp;
    end

    assign bf_x = mem[top];
    assign bf_y = mem[bot];
    assign bf_w = tw_data;

    // Results are only accepted while pairs are in flight, so stray or
    // post-reset bf_valid pulses cannot corrupt memory.
    assign wb_en     = bf_valid && (outstanding != '0) && !rst_n;
    assign last_pair = (pair == LOGN'(N / 2 - 1));
    assign last_wb   = wb_en && !bf_en && (outstanding == OW'(1));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= IDLE;
            stage       <= '0;
            pair        <= '0;
            outstanding <= '0;
            bf_en       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                sr_top[k] <= '0;
                sr_bot[k] <= '0;
            end
        end else begin
            // Address delay line tracks the butterfly pipeline cycle for cycle.
            sr_top[0] <= top;
            sr_bot[0] <= bot;
            for (int k = 1; k < PIPE_LAT; k++) begin
                sr_top[k] <= sr_top[k-1];
                sr_bot[k] <= sr_bot[k-1];
            end

            case ({bf_en, wb_en})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase

            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        stage <= '0;
                        pair  <= '0;
                        bf_en <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    pair <= pair + 1'b1;
                    if (last_pair) begin
                        state <= DRAIN;
                        pair  <= '0;
                        bf_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Next stage may only read once every result of this one is back.
                    if (last_wb) begin
                        if (stage == SW'(LOGN - 1)) begin
                            state <= DONE;
                            stage <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            stage <= stage + 1'b1;
                            bf_en <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Coefficient storage, deliberately not reset so an aborted run keeps its data.
    always_ff @(posedge clk) begin
        if (load_we && (state == IDLE || state == DONE)) begin
            mem[load_addr] <= load_data;
        end
        if (wb_en) begin
            mem[sr_top[PIPE_LAT-1]] <= bf_xout;
            mem[sr_bot[PIPE_LAT-1]] <= bf_yout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule
